bit_serializer: RTL

- Parallel-to-serial front end that feeds the serial pattern detector's bit input.
- Accepts DATA_W-bit words over a valid/ready handshake and emits them one bit at a time. Each bit is held for DIV clocks, with a one-cycle strobe at the start of each bit period.
- A one-word holding register lets back-to-back words go out with no gap between them.

---
 rtl/bit_serializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: words arrive over valid/ready, leave one bit per DIV clocks
// with a strobe on each bit's first clock; a one-word hold register allows gapless streaming.
module bit_serializer #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout_bit,
    output logic              dout_valid,
    output logic              busy
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int OUT_IDX = (MSB_FIRST != 0) ? DATA_W - 1 : 0;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        state_q,     state_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic [DATA_W-1:0] hold_q,      hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  div_cnt_q,   div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;

    logic [DATA_W-1:0] shift_adv;
    logic              transfer;
    logic              period_end;
    logic              word_end;

    // Shift register advanced by one bit, moving the next bit into the OUT_IDX position.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_adv
        if (MSB_FIRST != 0) begin : g_msb
            if (gi == 0) begin : g_edge
                assign shift_adv[gi] = 1'b0;
            end else begin : g_mid
                assign shift_adv[gi] = shift_q[gi-1];
            end
        end else begin : g_lsb
            if (gi == DATA_W - 1) begin : g_edge
                assign shift_adv[gi] = 1'b0;
            end else begin : g_mid
                assign shift_adv[gi] = shift_q[gi+1];
            end
        end
    end

    assign din_ready  = !hold_full_q;
    assign transfer   = din_valid && din_ready;
    assign period_end = (div_cnt_q == DIV_LAST);
    assign word_end   = period_end && (bit_cnt_q == BIT_LAST);

    assign busy       = (state_q == ST_SHIFT);
    assign dout_valid = busy && (div_cnt_q == '0);
    assign dout_bit   = busy && shift_q[OUT_IDX];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                if (transfer) begin
                    shift_d = din;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (period_end) begin
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end

                if (word_end) begin
                    bit_cnt_d = '0;
                    // hold_full and a new transfer are mutually exclusive here since din_ready=!hold_full
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (transfer) begin
                        shift_d = din;
                    end else begin
                        shift_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (period_end) begin
                        shift_d   = shift_adv;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                    if (transfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule
